// File: rtl/proc_out_pkg.sv
// Shared types and the strobe decoder for the processor output collector.
package proc_out_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CH_W_DEF   = 3;
    localparam int MAX_OUT    = 1 << CH_W_DEF;

    typedef logic [CH_W_DEF-1:0] chan_t;

    typedef struct packed {
        logic  valid;
        chan_t idx;
    } onehot_t;

    // valid only when exactly one of bits 1..MAX_OUT-1 is set and bit 0 is clear.
    function automatic onehot_t onehot_idx(input logic [MAX_OUT-1:0] out_en);
        onehot_t     res;
        int unsigned cnt;
        res = '0;
        cnt = 0;
        for (int k = 1; k < MAX_OUT; k++) begin
            if (out_en[k]) begin
                cnt++;
                res.idx = chan_t'(k);
            end
        end
        res.valid = (cnt == 1) && !out_en[0];
        return res;
    endfunction

endpackage

// File: rtl/chan_fifo.sv
// Synchronous show-ahead FIFO: rdata shows the head entry whenever empty is low.
module chan_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // NOTE: state uses <= so every register samples pre-edge values; = here would order-depend.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/proc_out_collector.sv
// Per-channel capture of processor output words, drained round-robin onto one tagged stream.
// Optional PROC_OUT_COLLECTOR_TSTAMP_EN adds a cycle timestamp per word on m_tstamp.
module proc_out_collector
    import proc_out_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_OUT  = 7,
    parameter int DEPTH  = 8,
    parameter int CH_W   = CH_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] io_out,
    input  logic [N_OUT-1:0]  out_en,
    output logic [DATA_W-1:0] m_data,
    output logic [CH_W-1:0]   m_chan,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N_OUT-1:0]  ovf,
    output logic              err_onehot,
    input  logic              clr_flags
`ifdef PROC_OUT_COLLECTOR_TSTAMP_EN
    ,
    output logic [31:0]       m_tstamp
`endif
);

`ifdef PROC_OUT_COLLECTOR_TSTAMP_EN
    localparam int FW = DATA_W + 32;
    logic [31:0] tstamp_cnt;
`else
    localparam int FW = DATA_W;
`endif

    logic [MAX_OUT-1:0] en_ext;
    onehot_t            dec;
    logic               bad_strobe;
    logic [FW-1:0]      wdata;
    logic [FW-1:0]      rdata [N_OUT];
    logic [N_OUT-1:0]   push_v, pop_v, full_v, empty_v, ovf_set;
    logic               load_en;
    logic               pick_valid;
    logic [CH_W-1:0]    pick_ch;
    logic [FW-1:0]      pick_data;
    logic [CH_W-1:0]    rr_ptr;

    assign en_ext     = MAX_OUT'(out_en);
    assign dec        = onehot_idx(en_ext);
    assign bad_strobe = (|out_en[N_OUT-1:1]) && !dec.valid;
    assign load_en    = !m_valid || m_ready;

`ifdef PROC_OUT_COLLECTOR_TSTAMP_EN
    assign wdata = {tstamp_cnt, io_out};
`else
    assign wdata = io_out;
`endif

    assign rdata[0]   = '0;
    assign full_v[0]  = 1'b0;
    assign empty_v[0] = 1'b1;

    for (genvar k = 1; k < N_OUT; k++) begin : g_ch
        chan_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_v[k]),
            .wdata (wdata),
            .pop   (pop_v[k]),
            .rdata (rdata[k]),
            .full  (full_v[k]),
            .empty (empty_v[k])
        );
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        pick_valid = 1'b0;
        pick_ch    = '0;
        pick_data  = '0;
        // Two passes give the wrap: rr_ptr..N_OUT-1 first, then 1..rr_ptr-1.
        for (int k = 1; k < N_OUT; k++) begin
            if (!pick_valid && !empty_v[k] && k >= int'(rr_ptr)) begin
                pick_valid = 1'b1;
                pick_ch    = CH_W'(k);
                pick_data  = rdata[k];
            end
        end
        for (int k = 1; k < N_OUT; k++) begin
            if (!pick_valid && !empty_v[k] && k < int'(rr_ptr)) begin
                pick_valid = 1'b1;
                pick_ch    = CH_W'(k);
                pick_data  = rdata[k];
            end
        end
    end

    always_comb begin
        push_v  = '0;
        pop_v   = '0;
        ovf_set = '0;
        for (int k = 1; k < N_OUT; k++) begin
            push_v[k]  = dec.valid && (int'(dec.idx) == k);
            pop_v[k]   = load_en && pick_valid && (int'(pick_ch) == k);
            ovf_set[k] = push_v[k] && full_v[k] && !pop_v[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= '0;
            rr_ptr  <= CH_W'(1);
        end else if (load_en) begin
            m_valid <= pick_valid;
            if (pick_valid) begin
                m_data <= pick_data[DATA_W-1:0];
                m_chan <= pick_ch;
                rr_ptr <= (int'(pick_ch) == N_OUT - 1) ? CH_W'(1) : pick_ch + 1'b1;
            end
        end
    end

    // Set wins over clear when both land on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf        <= '0;
            err_onehot <= 1'b0;
        end else begin
            ovf        <= (clr_flags ? '0 : ovf) | ovf_set;
            err_onehot <= (clr_flags ? 1'b0 : err_onehot) | bad_strobe;
        end
    end

`ifdef PROC_OUT_COLLECTOR_TSTAMP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tstamp_cnt <= '0;
            m_tstamp   <= '0;
        end else begin
            tstamp_cnt <= tstamp_cnt + 1'b1;
            if (load_en && pick_valid) m_tstamp <= pick_data[FW-1:DATA_W];
        end
    end
`endif

endmodule

// File: tb/tb_proc_out_collector.sv
// Directed bench for proc_out_collector: capture, round-robin drain, overflow, strobe errors, reset.
module tb_proc_out_collector;

    localparam int DATA_W = 32;
    localparam int N_OUT  = 7;
    localparam int CH_W   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] io_out;
    logic [N_OUT-1:0]  out_en;
    logic [DATA_W-1:0] m_data;
    logic [CH_W-1:0]   m_chan;
    logic              m_valid;
    logic              m_ready;
    logic [N_OUT-1:0]  ovf;
    logic              err_onehot;
    logic              clr_flags;
`ifdef PROC_OUT_COLLECTOR_TSTAMP_EN
    logic [31:0]       m_tstamp;
`endif

    int checks = 0;
    int errors = 0;

    proc_out_collector #(.DATA_W(DATA_W), .N_OUT(N_OUT), .DEPTH(8), .CH_W(CH_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .io_out     (io_out),
        .out_en     (out_en),
        .m_data     (m_data),
        .m_chan     (m_chan),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .ovf        (ovf),
        .err_onehot (err_onehot),
        .clr_flags  (clr_flags)
`ifdef PROC_OUT_COLLECTOR_TSTAMP_EN
        ,
        .m_tstamp   (m_tstamp)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; io_out = '0; out_en = '0; m_ready = 1'b0; clr_flags = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_chan !== '0) begin
            errors++;
            $display("FAIL reset_slot: got v=%b d=%0d ch=%0d expected v=0 d=0 ch=0", m_valid, m_data, m_chan);
        end
        checks++;
        if (ovf !== '0 || err_onehot !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got ovf=%b err=%b expected 0/0", ovf, err_onehot);
        end
    endtask

    task automatic test_single();
        m_ready = 1'b1; out_en = 7'd2; io_out = 32'hFFFF_FFFB;
        tick();
        out_en = '0; io_out = '0;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL single_latency: got v=%b expected 0 after E0", m_valid);
        end
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_chan !== 3'd1 || m_data !== 32'hFFFF_FFFB) begin
            errors++;
            $display("FAIL single_word: got v=%b ch=%0d d=%h expected v=1 ch=1 d=fffffffb", m_valid, m_chan, m_data);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain: got v=%b expected 0", m_valid);
        end
    endtask

    task automatic test_round_robin();
        m_ready = 1'b0;
        out_en = 7'd4;  io_out = 32'd10; tick();
        out_en = 7'd8;  io_out = 32'd20; tick();
        out_en = 7'd16; io_out = 32'd30; tick();
        out_en = '0;    io_out = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (m_valid !== 1'b1 || m_chan !== 3'd2 || m_data !== 32'd10) begin
                errors++;
                $display("FAIL rr_hold[%0d]: got v=%b ch=%0d d=%0d expected v=1 ch=2 d=10", i, m_valid, m_chan, m_data);
            end
        end
        m_ready = 1'b1;
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_chan !== 3'd3 || m_data !== 32'd20) begin
            errors++;
            $display("FAIL rr_second: got v=%b ch=%0d d=%0d expected v=1 ch=3 d=20", m_valid, m_chan, m_data);
        end
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_chan !== 3'd4 || m_data !== 32'd30) begin
            errors++;
            $display("FAIL rr_third: got v=%b ch=%0d d=%0d expected v=1 ch=4 d=30", m_valid, m_chan, m_data);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL rr_empty: got v=%b expected 0", m_valid);
        end
    endtask

    task automatic test_overflow();
        int n;
        m_ready = 1'b0;
        for (int v = 1; v <= 10; v++) begin
            out_en = 7'd64; io_out = 32'(v);
            tick();
        end
        out_en = '0; io_out = '0;
        checks++;
        if (ovf !== 7'b100_0000) begin
            errors++; $display("FAIL ovf_flag: got %b expected 1000000", ovf);
        end
        m_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (m_valid === 1'b1) begin
                checks++;
                if (n >= 9 || m_chan !== 3'd6 || m_data !== 32'(n + 1)) begin
                    errors++;
                    $display("FAIL ovf_stream[%0d]: got ch=%0d d=%0d expected ch=6 d=%0d", n, m_chan, m_data, n + 1);
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n !== 9) begin
            errors++; $display("FAIL ovf_count: got %0d words expected 9", n);
        end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        checks++;
        if (ovf !== '0) begin
            errors++; $display("FAIL ovf_clear: got %b expected 0", ovf);
        end
    endtask

    task automatic test_full_pop();
        int exp_v [9] = '{102, 103, 104, 105, 106, 107, 108, 109, 99};
        int n;
        m_ready = 1'b0;
        for (int v = 101; v <= 109; v++) begin
            out_en = 7'd2; io_out = 32'(v);
            tick();
        end
        // Slot holds 101 and the FIFO is full; push 99 on the edge that pops.
        m_ready = 1'b1; out_en = 7'd2; io_out = 32'd99;
        tick();
        out_en = '0; io_out = '0;
        checks++;
        if (ovf !== '0) begin
            errors++; $display("FAIL fullpop_ovf: got %b expected 0", ovf);
        end
        n = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (m_valid === 1'b1) begin
                checks++;
                if (n >= 9 || m_chan !== 3'd1 || m_data !== 32'(exp_v[n % 9])) begin
                    errors++;
                    $display("FAIL fullpop_stream[%0d]: got ch=%0d d=%0d expected ch=1 d=%0d", n, m_chan, m_data, exp_v[n % 9]);
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n !== 9) begin
            errors++; $display("FAIL fullpop_count: got %0d words expected 9", n);
        end
    endtask

    task automatic test_illegal();
        m_ready = 1'b1;
        out_en = 7'd6; io_out = 32'd77; tick();
        out_en = '0;
        checks++;
        if (err_onehot !== 1'b1) begin
            errors++; $display("FAIL illegal_set: got %b expected 1", err_onehot);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++; $display("FAIL illegal_nopush: got v=%b expected 0", m_valid);
        end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        checks++;
        if (err_onehot !== 1'b0) begin
            errors++; $display("FAIL illegal_clear: got %b expected 0", err_onehot);
        end
        clr_flags = 1'b1; out_en = 7'd3; tick(); clr_flags = 1'b0; out_en = '0;
        checks++;
        if (err_onehot !== 1'b1) begin
            errors++; $display("FAIL illegal_setwins: got %b expected 1", err_onehot);
        end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        out_en = 7'd1; tick(); out_en = '0;
        tick();
        checks++;
        if (err_onehot !== 1'b0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL bit0_ignored: got err=%b v=%b expected 0/0", err_onehot, m_valid);
        end
        out_en = 7'b100_0001; tick(); out_en = '0;
        checks++;
        if (err_onehot !== 1'b1) begin
            errors++; $display("FAIL bit0_plus_ch: got %b expected 1", err_onehot);
        end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        m_ready = 1'b0;
        for (int v = 7; v <= 9; v++) begin
            out_en = 7'd8; io_out = 32'(v);
            tick();
        end
        out_en = 7'd6; tick(); out_en = '0;
        checks++;
        if (m_valid !== 1'b1 || err_onehot !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: got v=%b err=%b expected 1/1", m_valid, err_onehot);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || ovf !== '0 || err_onehot !== 1'b0 || m_data !== '0) begin
            errors++;
            $display("FAIL midrst_state: got v=%b ovf=%b err=%b d=%0d expected 0/0/0/0", m_valid, ovf, err_onehot, m_data);
        end
        m_ready = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (m_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL midrst_stale: got %0d words expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_full_pop();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
